mdu_responder: RTL and testbench
================================

// Module: mdu_responder
// PURPOSE
//  Iterative multiply/divide unit. It is the responder to the multicycle control unit's start/busy/done handshake.
//  On a start strobe it latches the two register operands. It runs a 1-bit-per-cycle shift-add multiply or restoring divide,
//  then writes the HI/LO pair. The datapath reads HI/LO for MFHI/MFLO and writes them directly for MTHI/MTLO.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits, the product is 2*WIDTH bits
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      reset, asynchronous, active-high
//  start   in   1      1-cycle request; sampled only while busy==0
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val  in   WIDTH  multiplicand / dividend
//  rt_val  in   WIDTH  multiplier / divisor
//  hi_we   in   1      MTHI write strobe
//  lo_we   in   1      MTLO write strobe
//  wdata   in   WIDTH  MTHI/MTLO data
//  busy    out  1      operation in flight
//  done    out  1      1-cycle pulse; HI/LO hold the new result in this cycle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
//  dz_err  out  1      divide-by-zero flag (MDU_DIVZERO_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, dz_err=0, hi=0, lo=0, iteration counter=0, operand/accumulator regs=0.
//  - States and transitions:
//    - IDLE -> PREP on start.
//    - PREP -> CALC.
//    - CALC -> CALC for WIDTH cycles, counter WIDTH-1 down to 0.
//    - CALC -> FIX when the counter hits 0.
//    - FIX -> DONE.
//    - DONE -> PREP if start, else IDLE.
//  - PREP: latch op. Signed ops (MULT, DIV) take the two's-complement magnitude of each operand and record the result signs.
//    - Product and quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
//  - CALC multiply: shift-add over a 2*WIDTH accumulator, LSB of the multiplier first.
//  - CALC divide: restoring divide. Remainder shifts left with the next dividend bit; subtract if rem>=divisor; quotient bit = 1 on subtract.
//  - FIX: negate the magnitudes as the recorded signs require, then write hi/lo at the end of FIX.
//    - Multiply: {hi,lo} = 2*WIDTH product.
//    - Divide: lo = quotient truncated toward zero, hi = remainder.
//  - Latency: start sampled at edge T (state IDLE) -> busy=1 from T+1 through end of FIX.
//    - With WIDTH=32, done=1 in cycle T+35, busy=0 in that cycle, hi/lo valid.
//  - busy=1 in PREP, CALC and FIX; done=1 only in DONE.
//  - start while busy=1 is ignored (no queueing).
//  - start in the DONE cycle is accepted: back-to-back operation.
//  - hi_we/lo_we while busy=0: register loads wdata at the next edge.
//    - If hi_we/lo_we coincides with an accepted start, the write lands, then the op result overwrites it in FIX.
//  - hi_we/lo_we while busy=1: ignored; hi/lo hold their old values until FIX.
//  - MULT edge case: rs=rt=0x80000000 gives magnitudes 2^31 each; product 2^62 -> hi=0x40000000, lo=0.
//  - DIV edge case: rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000 (wraps), hi=0.
//  - Divisor zero without the macro: the algorithm runs the full latency.
//    - DIVU: lo=0xFFFFFFFF, hi=rs.
//    - DIV: lo=0xFFFFFFFF if rs>=0, else 0x00000001; hi=rs.
//  - Reset mid-operation aborts: state IDLE, hi/lo cleared, no done pulse.
// CONFIGURATION
//  MDU_DIVZERO_EN defined:
//   - DIV/DIVU with rt_val==0 go PREP -> DONE, skipping CALC and FIX.
//   - done and dz_err both pulse in cycle T+2; hi/lo unchanged.
//   - dz_err=0 for every other completion.
//  MDU_DIVZERO_EN undefined:
//   - dz_err tied 0.
//   - Divide-by-zero runs the full WIDTH+3 cycles with the results above.
// TESTING
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at T+35, hi=0xFFFFFFFE, lo=0x00000001, busy high T+1..T+34.
//  - MULT (-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - DIVU 5/0:
//    - Without the macro -> done T+35, lo=0xFFFFFFFF, hi=5.
//    - With MDU_DIVZERO_EN -> done and dz_err at T+2, hi/lo unchanged.
//  - Handshake: second start mid-CALC is ignored; start in the DONE cycle begins a new op with done 35 cycles later.
//    - hi_we while busy leaves hi unchanged; hi_we in IDLE with wdata=0x1234 -> hi=0x1234 next cycle.
//  - Assert rst at T+10 of a MULT -> busy=0, hi=lo=0 immediately, no done pulse; a new op after release completes normally.

Source files
------------

// File: rtl/mdu_responder_if.sv
// Bus between the multicycle control unit (master) and the multiply/divide unit (slave).
// Carries the start/busy/done handshake, the operands, the MTHI/MTLO write port and the HI/LO results.
interface mdu_responder_if #(
   parameter int WIDTH = 32
);
   // Handshake: the master pulses start for one cycle while busy==0.
   // The slave raises busy on the next cycle and holds it through the whole operation.
   // It then pulses done for one cycle, and hi/lo hold the result in that cycle.
   // A start pulse seen while busy==1 is dropped. A start pulse in the done cycle is accepted.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dz_err;

   modport master (
      output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
      input  busy, done, hi, lo, dz_err
   );

   modport slave (
      input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
      output busy, done, hi, lo, dz_err
   );
endinterface

// File: rtl/mdu_responder.sv
// Iterative 1-bit-per-cycle multiply (shift-add) / restoring divide unit owning the HI/LO pair.
// Optional macro MDU_DIVZERO_EN: divide by zero finishes early with dz_err instead of running the algorithm.
module mdu_responder #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   mdu_responder_if.slave     bus,
   output logic [2:0]         o_dbg_state
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
`ifdef MDU_DIVZERO_EN
   logic               r_dz;
   logic               w_div_zero;
`endif

   logic               w_signed;
   logic               w_is_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   always_comb begin
      w_signed    = ~r_op[0];
      w_is_div    = r_op[1];
      w_a_neg     = w_signed & r_a[WIDTH-1];
      w_b_neg     = w_signed & r_b[WIDTH-1];
      w_a_mag     = w_a_neg ? -r_a : r_a;
      w_b_mag     = w_b_neg ? -r_b : r_b;
      // Multiply: accumulator is {partial product, remaining multiplier bits}.
      w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
      // Divide: accumulator is {remainder, dividend bits shifting out / quotient bits shifting in}.
      w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_div_ge    = w_div_shift >= {1'b0, r_b};
      w_div_rem   = w_div_shift[WIDTH-1:0] - (w_div_ge ? r_b : {WIDTH{1'b0}});
      w_prod      = r_neg_q ? -r_acc : r_acc;
      w_quot      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`ifdef MDU_DIVZERO_EN
      w_div_zero  = w_is_div && (r_b == {WIDTH{1'b0}});
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= 2'b00;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
`ifdef MDU_DIVZERO_EN
         r_dz    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef MDU_DIVZERO_EN
         r_dz   <= 1'b0;
`endif
         case (r_state)
            S_IDLE, S_DONE: begin
               // MTHI/MTLO land even when a start is accepted on the same edge.
               if (bus.hi_we) r_hi <= bus.wdata;
               if (bus.lo_we) r_lo <= bus.wdata;
               if (bus.start) begin
                  r_op    <= bus.op;
                  r_a     <= bus.rs_val;
                  r_b     <= bus.rt_val;
                  r_busy  <= 1'b1;
                  r_state <= S_PREP;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PREP: begin
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               r_b     <= w_b_mag;
               r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
               r_cnt   <= CW'(WIDTH - 1);
               r_state <= S_CALC;
`ifdef MDU_DIVZERO_EN
               if (w_div_zero) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_dz    <= 1'b1;
                  r_state <= S_DONE;
               end
`endif
            end
            S_CALC: begin
               if (w_is_div) r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
               else          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               if (r_cnt == '0) r_state <= S_FIX;
               else             r_cnt   <= r_cnt - CW'(1);
            end
            S_FIX: begin
               if (w_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.hi      = r_hi;
   assign bus.lo      = r_lo;
`ifdef MDU_DIVZERO_EN
   assign bus.dz_err  = r_dz;
`else
   assign bus.dz_err  = 1'b0;
`endif
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mdu_responder.sv
// Bench for mdu_responder: scoreboard of expected {dz_err, hi, lo} and latency per accepted start.
// Expected values come from native 64-bit arithmetic in the model function below.
module tb_mdu_responder;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   mdu_responder_if #(.WIDTH(32)) bus ();

   mdu_responder #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [64:0] exp_q[$];
   int          lat_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, b, ch, cl);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      logic [31:0] uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin sq = sa * sb; p = sq; return {1'b0, p}; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
         2'b10: begin
            if (b == 0) begin
`ifdef MDU_DIVZERO_EN
               return {1'b1, ch, cl};
`else
               return {1'b0, a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
            end
            sq = sa / sb;
            sr = sa % sb;
            uq = sq[31:0];
            ur = sr[31:0];
            return {1'b0, ur, uq};
         end
         default: begin
            if (b == 0) begin
`ifdef MDU_DIVZERO_EN
               return {1'b1, ch, cl};
`else
               return {1'b0, a, 32'hFFFF_FFFF};
`endif
            end
            uq = a / b;
            ur = a % b;
            return {1'b0, ur, uq};
         end
      endcase
   endfunction

   // Drives a start (caller is at a negedge) and pushes the expected outcome.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, b);
      logic [64:0] r;
      int          lat;
      bus.start  = 1'b1;
      bus.op     = op;
      bus.rs_val = a;
      bus.rt_val = b;
      if (bus.hi_we) m_hi = bus.wdata;
      if (bus.lo_we) m_lo = bus.wdata;
      r   = model(op, a, b, m_hi, m_lo);
      lat = 35;
`ifdef MDU_DIVZERO_EN
      if (op[1] && b == 0) lat = 2;
`endif
      exp_q.push_back(r);
      lat_q.push_back(lat);
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   // Waits (bounded) for done; reports cycles counted from the start edge and whether busy behaved.
   task automatic wait_done(output int lat, output logic busy_ok, output logic [31:0] hi, lo,
                            output logic dz);
      lat = 0; busy_ok = 1'b1; hi = '0; lo = '0; dz = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
         bus.lo_we = 1'b0;
         if (bus.done) begin
            lat = k;
            if (bus.busy) busy_ok = 1'b0;
            hi = bus.hi;
            lo = bus.lo;
            dz = bus.dz_err;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
      bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.dz_err} !== 3'b000)
         $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.dz_err});
      else n_pass++;
      n_checks++;
      if ({bus.hi, bus.lo} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
      else n_pass++;
      n_checks++;
      if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
      else n_pass++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, dbg_state} !== 5'b0) $display("FAIL post_reset_idle: got %b expected 0", {bus.busy, bus.done, dbg_state});
      else n_pass++;
   endtask

   task automatic test_arith();
      logic [1:0]  ops[8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
      logic [31:0] as[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFF8};
      logic [31:0] bs[8]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                              32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic [64:0] e;
      logic        busy_ok, dz;
      int          lat, le;
      for (int i = 0; i < 18; i++) begin
         if (i < 8) begin
            op = ops[i]; a = as[i]; b = bs[i];
         end else begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
         end
         start_op(op, a, b);
         wait_done(lat, busy_ok, hi, lo, dz);
         e  = exp_q.pop_front();
         le = lat_q.pop_front();
         n_checks++;
         if (lat !== le) $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, le);
         else n_pass++;
         n_checks++;
         if (!busy_ok) $display("FAIL op%0d_busy: got busy pattern wrong expected high until done", i);
         else n_pass++;
         n_checks++;
         if (hi !== e[63:32]) $display("FAIL op%0d_hi: op=%0d a=%h b=%h got %h expected %h", i, op, a, b, hi, e[63:32]);
         else n_pass++;
         n_checks++;
         if (lo !== e[31:0]) $display("FAIL op%0d_lo: op=%0d a=%h b=%h got %h expected %h", i, op, a, b, lo, e[31:0]);
         else n_pass++;
         n_checks++;
         if (dz !== e[64]) $display("FAIL op%0d_dz: got %b expected %b", i, dz, e[64]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] hi, lo;
      logic [64:0] e;
      logic        busy_ok, dz;
      int          lat, le;
      start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, busy_ok, hi, lo, dz);
      e = exp_q.pop_front(); le = lat_q.pop_front();
      n_checks++;
      if ({hi, lo} !== e[63:0]) $display("FAIL b2b_first: got %h expected %h", {hi, lo}, e[63:0]);
      else n_pass++;
      // Start issued in the done cycle itself.
      start_op(2'b11, 32'd100, 32'd7);
      wait_done(lat, busy_ok, hi, lo, dz);
      e = exp_q.pop_front(); le = lat_q.pop_front();
      n_checks++;
      if (lat !== le) $display("FAIL b2b_latency: got %0d expected %0d", lat, le);
      else n_pass++;
      n_checks++;
      if ({hi, lo} !== e[63:0]) $display("FAIL b2b_second: got %h expected %h", {hi, lo}, e[63:0]);
      else n_pass++;
   endtask

   task automatic test_ignore_busy();
      logic [31:0] hi, lo, old_hi;
      logic [64:0] e;
      logic        busy_ok, dz;
      int          lat, le, extra_done;
      old_hi = m_hi;
      start_op(2'b11, 32'd1000, 32'd9);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.hi_we = 1'b0;
         if (k == 10) begin
            bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd77; bus.rt_val = 32'd3;
            bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
         end
      end
      n_checks++;
      if (bus.hi !== old_hi) $display("FAIL busy_hi_we: got %h expected %h", bus.hi, old_hi);
      else n_pass++;
      wait_done(lat, busy_ok, hi, lo, dz);
      e = exp_q.pop_front(); le = lat_q.pop_front();
      n_checks++;
      if (lat + 11 !== le) $display("FAIL busy_start_latency: got %0d expected %0d", lat + 11, le);
      else n_pass++;
      n_checks++;
      if ({hi, lo} !== e[63:0]) $display("FAIL busy_start_result: got %h expected %h", {hi, lo}, e[63:0]);
      else n_pass++;
      extra_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) extra_done++;
      end
      n_checks++;
      if (extra_done !== 0) $display("FAIL busy_start_queued: got %0d done pulses expected 0", extra_done);
      else n_pass++;
   endtask

   task automatic test_mt_regs();
      logic [31:0] hi, lo;
      logic [64:0] e;
      logic        busy_ok, dz;
      int          lat, le;
      bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
      @(negedge clk);
      bus.hi_we = 1'b0; m_hi = 32'h0000_1234;
      n_checks++;
      if (bus.hi !== 32'h0000_1234) $display("FAIL mthi: got %h expected 00001234", bus.hi);
      else n_pass++;
      bus.lo_we = 1'b1; bus.wdata = 32'h0000_5678;
      @(negedge clk);
      bus.lo_we = 1'b0; m_lo = 32'h0000_5678;
      n_checks++;
      if ({bus.hi, bus.lo} !== 64'h0000_1234_0000_5678) $display("FAIL mtlo: got %h expected 0000123400005678", {bus.hi, bus.lo});
      else n_pass++;
      // Write coincident with an accepted start lands first, then the result replaces it.
      bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_5555;
      start_op(2'b01, 32'd2, 32'd3);
      @(negedge clk);
      bus.start = 1'b0; bus.hi_we = 1'b0;
      n_checks++;
      if (bus.hi !== 32'hAAAA_5555) $display("FAIL mthi_with_start: got %h expected aaaa5555", bus.hi);
      else n_pass++;
      wait_done(lat, busy_ok, hi, lo, dz);
      e = exp_q.pop_front(); le = lat_q.pop_front();
      n_checks++;
      if (lat + 1 !== le) $display("FAIL mthi_op_latency: got %0d expected %0d", lat + 1, le);
      else n_pass++;
      n_checks++;
      if ({hi, lo} !== e[63:0]) $display("FAIL mthi_op_result: got %h expected %h", {hi, lo}, e[63:0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] hi, lo;
      logic [64:0] e;
      logic        busy_ok, dz;
      int          lat, le, n_done;
      start_op(2'b00, 32'd12345, 32'hFFFF_FF9D);
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      m_hi = '0; m_lo = '0;
      n_checks++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0)
         $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected all 0", bus.busy, bus.done, bus.hi, bus.lo);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL reset_mid_done: got %0d pulses expected 0", n_done);
      else n_pass++;
      start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, busy_ok, hi, lo, dz);
      e = exp_q.pop_front(); le = lat_q.pop_front();
      n_checks++;
      if (lat !== le) $display("FAIL after_reset_latency: got %0d expected %0d", lat, le);
      else n_pass++;
      n_checks++;
      if ({hi, lo} !== e[63:0]) $display("FAIL after_reset_result: got %h expected %h", {hi, lo}, e[63:0]);
      else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_ignore_busy();
      test_mt_regs();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
